// File: rtl/neuron_layer_sequencer.sv
// Sequences a 16-lane multiply datapath over one fully connected layer, accumulating per-neuron partial sums.
// Latency: start -> first out_valid in N_CHUNKS+RD_LAT+MULT_LAT+1 cycles; each later neuron the same after its predecessor's handshake.
// Backpressure: out_valid/out_* hold until out_ready; no reads are issued while a result is waiting.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start/busy/done     layer control: start accepted in IDLE, busy until done, done is a 1-cycle pulse
//   rd_en/in_addr/w_addr  chunk read strobe and addresses to the input and weight memories
//   psum                signed 8-bit partial sum returned by the multiplier datapath
//   out_valid/out_ready valid/ready handshake for one neuron result
//   out_idx/out_value/out_bit  neuron index, saturated signed sum, binarized activation
module neuron_layer_sequencer #(
    parameter int N_CHUNKS  = 4,
    parameter int N_NEURONS = 10,
    parameter int ACC_W     = 12,
    parameter int RD_LAT    = 1,
    parameter int MULT_LAT  = 1,
    localparam int IA_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1,
    localparam int WA_W = (N_NEURONS * N_CHUNKS > 1) ? $clog2(N_NEURONS * N_CHUNKS) : 1,
    localparam int IX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [IA_W-1:0]  in_addr,
    output logic [WA_W-1:0]  w_addr,
    input  logic [7:0]       psum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IX_W-1:0]  out_idx,
    output logic [ACC_W-1:0] out_value,
    output logic             out_bit
);

    localparam int LAT = RD_LAT + MULT_LAT;
    localparam logic [IA_W-1:0]  LAST_CHUNK  = IA_W'(N_CHUNKS - 1);
    localparam logic [IX_W-1:0]  LAST_NEURON = IX_W'(N_NEURONS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN     = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IA_W-1:0]  in_addr_q, in_addr_d;     // doubles as the chunk counter
    logic [WA_W-1:0]  w_addr_q, w_addr_d;       // runs neuron*N_CHUNKS+chunk incrementally
    logic [IX_W-1:0]  neuron_q, neuron_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [LAT-1:0]   tag_last_q, tag_last_d;
    logic             out_valid_q, out_valid_d;
    logic [IX_W-1:0]  out_idx_q, out_idx_d;
    logic [ACC_W-1:0] out_value_q, out_value_d;
    logic             out_bit_q, out_bit_d;

    logic             issue;
    logic             retire;
    logic             retire_last;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_sat;

    assign issue       = (state_q == S_ISSUE);
    assign retire      = tag_vld_q[LAT-1];
    assign retire_last = retire & tag_last_q[LAT-1];

    // One guard bit is enough to detect overflow of a single 8-bit addend.
    always_comb begin
        sum_ext = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){psum[7]}}, psum};
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            acc_sat = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_sat = sum_ext[ACC_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        in_addr_d   = in_addr_q;
        w_addr_d    = w_addr_q;
        neuron_d    = neuron_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_value_d = out_value_q;
        out_bit_d   = out_bit_q;

        // Tag pipeline mirrors the memory + multiplier latency so psum is only
        // consumed in the cycle that belongs to an issued chunk.
        tag_vld_d[0]  = issue;
        tag_last_d[0] = issue && (in_addr_q == LAST_CHUNK);
        for (int i = 1; i < LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_last_d[i] = tag_last_q[i-1];
        end

        if (retire) begin
            acc_d = acc_sat;
        end

        case (state_q)
            S_IDLE: begin
                // done_q blocks a start landing in the cycle the layer completes.
                if (start && !done_q) begin
                    state_d   = S_ISSUE;
                    busy_d    = 1'b1;
                    neuron_d  = '0;
                    in_addr_d = '0;
                    w_addr_d  = '0;
                    acc_d     = '0;
                end
            end
            S_ISSUE: begin
                if (in_addr_q == LAST_CHUNK) begin
                    state_d = S_DRAIN;
                end else begin
                    in_addr_d = in_addr_q + IA_W'(1);
                    w_addr_d  = w_addr_q + WA_W'(1);
                end
            end
            S_DRAIN: begin
                if (retire_last) begin
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    out_idx_d   = neuron_q;
                    out_value_d = acc_sat;
                    out_bit_d   = ~acc_sat[ACC_W-1];
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    if (neuron_q != LAST_NEURON) begin
                        state_d   = S_ISSUE;
                        neuron_d  = neuron_q + IX_W'(1);
                        in_addr_d = '0;
                        w_addr_d  = w_addr_q + WA_W'(1);
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            neuron_q    <= '0;
            acc_q       <= '0;
            tag_vld_q   <= '0;
            tag_last_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_value_q <= '0;
            out_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_addr_q   <= in_addr_d;
            w_addr_q    <= w_addr_d;
            neuron_q    <= neuron_d;
            acc_q       <= acc_d;
            tag_vld_q   <= tag_vld_d;
            tag_last_q  <= tag_last_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_value_q <= out_value_d;
            out_bit_q   <= out_bit_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = issue;
    assign in_addr   = in_addr_q;
    assign w_addr    = w_addr_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_value = out_value_q;
    assign out_bit   = out_bit_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
module tb_neuron_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       out_ready;
    logic [7:0] psum;

    logic        busy, done, rd_en, out_valid, out_bit;
    logic [1:0]  in_addr;
    logic [2:0]  w_addr;
    logic [0:0]  out_idx;
    logic [11:0] out_value;

    logic        busy9, done9, rd_en9, out_valid9, out_bit9;
    logic [1:0]  in_addr9;
    logic [2:0]  w_addr9;
    logic [0:0]  out_idx9;
    logic [8:0]  out_value9;

    neuron_layer_sequencer #(
        .N_CHUNKS(4), .N_NEURONS(2), .ACC_W(12), .RD_LAT(1), .MULT_LAT(1)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .in_addr(in_addr), .w_addr(w_addr), .psum(psum),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_value(out_value), .out_bit(out_bit)
    );

    neuron_layer_sequencer #(
        .N_CHUNKS(4), .N_NEURONS(2), .ACC_W(9), .RD_LAT(1), .MULT_LAT(1)
    ) u_dut9 (
        .clk(clk), .rst(rst), .start(start), .busy(busy9), .done(done9),
        .rd_en(rd_en9), .in_addr(in_addr9), .w_addr(w_addr9), .psum(psum),
        .out_valid(out_valid9), .out_ready(out_ready), .out_idx(out_idx9),
        .out_value(out_value9), .out_bit(out_bit9)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t0 = 0;

    // Partial-sum table indexed by weight address; memory read (1 cycle) then
    // multiplier (1 cycle). Idle cycles carry junk that must be ignored.
    logic [7:0] tab [0:7];
    logic       s1_vld = 1'b0;
    logic [7:0] s1_dat = 8'h00;
    always @(posedge clk) begin
        s1_vld <= rd_en;
        s1_dat <= tab[w_addr];
        psum   <= s1_vld ? s1_dat : 8'h4D;
    end

    int rd_log[$];
    int hs_cyc[$];
    int hs_idx[$];
    int hs_val[$];
    int hs_bit[$];
    int hs9_val[$];
    int hs9_bit[$];
    int done_log[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) rd_log.push_back(cyc);
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                hs_idx.push_back(int'(out_idx));
                hs_val.push_back(int'($signed(out_value)));
                hs_bit.push_back(int'(out_bit));
            end
            if (out_valid9 && out_ready) begin
                hs9_val.push_back(int'($signed(out_value9)));
                hs9_bit.push_back(int'(out_bit9));
            end
            if (done) done_log.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete(); hs_cyc.delete(); hs_idx.delete(); hs_val.delete();
        hs_bit.delete(); hs9_val.delete(); hs9_bit.delete(); done_log.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic load_tab_a();
        tab[0] = 8'd3;   tab[1] = 8'd5;   tab[2] = 8'hFE; tab[3] = 8'd1;
        tab[4] = 8'hFC;  tab[5] = 8'hFC;  tab[6] = 8'd1;  tab[7] = 8'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, rd_en, out_valid, out_bit, in_addr, w_addr, out_idx, out_value} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd_en=%b vld=%b bit=%b ia=%0d wa=%0d idx=%0d val=%0d, expected all 0",
                     busy, done, rd_en, out_valid, out_bit, in_addr, w_addr, out_idx, out_value);
        end
        checks++;
        if ({busy9, done9, rd_en9, out_valid9, out_value9} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_acc9: got busy=%b done=%b rd_en=%b vld=%b val=%0d, expected all 0",
                     busy9, done9, rd_en9, out_valid9, out_value9);
        end
        out_ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({busy, rd_en, out_valid, done} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ready_no_effect: got busy=%b rd_en=%b vld=%b done=%b, expected 0000",
                     busy, rd_en, out_valid, done);
        end
    endtask

    // Layer with psums 3,5,-2,1 / -4,-4,1,0 and out_ready held high.
    // Optional extra start pulses during the layer and in the done cycle.
    task automatic run_layer_a(input string tag, input bit extra_starts);
        int exp_rd [8] = '{1, 2, 3, 4, 8, 9, 10, 11};
        int exp_hc [2] = '{7, 14};
        int exp_v  [2] = '{7, -7};
        int exp_b  [2] = '{1, 0};
        load_tab_a();
        clear_logs();
        out_ready = 1'b1;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_c1: got %b expected 1", tag, busy);
        end
        for (int c = 1; c < 25; c++) begin
            if (extra_starts && c == 16) begin
                checks++;
                if ({busy, rd_en} !== 2'b00) begin
                    errors++;
                    $display("FAIL %s_start_at_done: got busy=%b rd_en=%b expected 00", tag, busy, rd_en);
                end
            end
            start = extra_starts && (c == 2 || c == 8 || c == 15);
            tick();
        end
        start = 1'b0;
        checks++;
        if (rd_log.size() != 8) begin
            errors++;
            $display("FAIL %s_rd_count: got %0d expected 8", tag, rd_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rd_log[i] - t0 !== exp_rd[i]) begin
                    errors++;
                    $display("FAIL %s_rd_cycle[%0d]: got %0d expected %0d", tag, i, rd_log[i] - t0, exp_rd[i]);
                end
            end
        end
        checks++;
        if (hs_cyc.size() != 2) begin
            errors++;
            $display("FAIL %s_result_count: got %0d expected 2", tag, hs_cyc.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (hs_cyc[i] - t0 !== exp_hc[i] || hs_idx[i] !== i || hs_val[i] !== exp_v[i] || hs_bit[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL %s_result[%0d]: got cyc=%0d idx=%0d val=%0d bit=%0d expected cyc=%0d idx=%0d val=%0d bit=%0d",
                             tag, i, hs_cyc[i] - t0, hs_idx[i], hs_val[i], hs_bit[i], exp_hc[i], i, exp_v[i], exp_b[i]);
                end
            end
        end
        checks++;
        if (done_log.size() != 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d expected 1", tag, done_log.size());
        end else begin
            checks++;
            if (done_log[0] - t0 !== 15) begin
                errors++;
                $display("FAIL %s_done_cycle: got %0d expected 15", tag, done_log[0] - t0);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_end: got %b expected 0", tag, busy);
        end
    endtask

    task automatic test_basic();
        run_layer_a("basic", 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) tab[i] = 8'h7F;
        for (int i = 4; i < 8; i++) tab[i] = 8'h80;
        clear_logs();
        out_ready = 1'b1;
        pulse_start();
        repeat (20) tick();
        checks++;
        if (hs9_val.size() != 2) begin
            errors++;
            $display("FAIL sat9_count: got %0d expected 2", hs9_val.size());
        end else begin
            checks++;
            if (hs9_val[0] !== 255 || hs9_bit[0] !== 1) begin
                errors++;
                $display("FAIL sat9_pos: got val=%0d bit=%0d expected val=255 bit=1", hs9_val[0], hs9_bit[0]);
            end
            checks++;
            if (hs9_val[1] !== -256 || hs9_bit[1] !== 0) begin
                errors++;
                $display("FAIL sat9_neg: got val=%0d bit=%0d expected val=-256 bit=0", hs9_val[1], hs9_bit[1]);
            end
        end
        checks++;
        if (hs_val.size() != 2) begin
            errors++;
            $display("FAIL wide_count: got %0d expected 2", hs_val.size());
        end else begin
            checks++;
            if (hs_val[0] !== 508 || hs_val[1] !== -512) begin
                errors++;
                $display("FAIL wide_nosat: got %0d,%0d expected 508,-512", hs_val[0], hs_val[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        load_tab_a();
        clear_logs();
        out_ready = 1'b0;
        pulse_start();
        repeat (6) tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 1'b0 || $signed(out_value) !== 12'sd7 || out_bit !== 1'b1 || rd_en !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got vld=%b idx=%0d val=%0d bit=%b rd_en=%b expected vld=1 idx=0 val=7 bit=1 rd_en=0",
                         7 + i, out_valid, out_idx, $signed(out_value), out_bit, rd_en);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (rd_en !== 1'b1 || in_addr !== 2'd0 || w_addr !== 3'd4) begin
            errors++;
            $display("FAIL resume_issue: got rd_en=%b ia=%0d wa=%0d expected rd_en=1 ia=0 wa=4", rd_en, in_addr, w_addr);
        end
        repeat (12) tick();
        checks++;
        if (hs_cyc.size() != 2) begin
            errors++;
            $display("FAIL bp_result_count: got %0d expected 2", hs_cyc.size());
        end else begin
            checks++;
            if (hs_cyc[0] - t0 !== 12 || hs_cyc[1] - t0 !== 19 || hs_val[1] !== -7) begin
                errors++;
                $display("FAIL bp_results: got cyc=%0d,%0d val1=%0d expected cyc=12,19 val1=-7",
                         hs_cyc[0] - t0, hs_cyc[1] - t0, hs_val[1]);
            end
        end
        checks++;
        if (done_log.size() != 1 || (done_log.size() == 1 && done_log[0] - t0 !== 20)) begin
            errors++;
            $display("FAIL bp_done: got count=%0d expected one pulse at cycle 20", done_log.size());
        end
    endtask

    task automatic test_mid_reset();
        load_tab_a();
        clear_logs();
        out_ready = 1'b1;
        pulse_start();
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, rd_en, out_valid, out_bit, in_addr, w_addr, out_idx, out_value} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b done=%b rd_en=%b vld=%b bit=%b ia=%0d wa=%0d idx=%0d val=%0d, expected all 0",
                     busy, done, rd_en, out_valid, out_bit, in_addr, w_addr, out_idx, out_value);
        end
        repeat (4) tick();
        checks++;
        if ({busy, rd_en, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_stays_idle: got busy=%b rd_en=%b vld=%b expected 000", busy, rd_en, out_valid);
        end
        run_layer_a("rerun", 1'b0);
    endtask

    task automatic test_start_ignored();
        run_layer_a("start_busy", 1'b1);
    endtask

    task automatic test_zero();
        for (int i = 0; i < 8; i++) tab[i] = 8'h00;
        clear_logs();
        out_ready = 1'b1;
        pulse_start();
        repeat (20) tick();
        checks++;
        if (hs_val.size() != 2 || hs9_val.size() != 2) begin
            errors++;
            $display("FAIL zero_count: got %0d,%0d expected 2,2", hs_val.size(), hs9_val.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (hs_val[i] !== 0 || hs_bit[i] !== 1 || hs9_val[i] !== 0 || hs9_bit[i] !== 1) begin
                    errors++;
                    $display("FAIL zero_result[%0d]: got val=%0d bit=%0d val9=%0d bit9=%0d expected 0,1,0,1",
                             i, hs_val[i], hs_bit[i], hs9_val[i], hs9_bit[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tab[i] = 8'h00;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_mid_reset();
        test_start_ignored();
        test_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
